// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and default widths.
//   XLEN_DEF        : address / PC width
//   ILEN_DEF        : instruction width
//   INSTR_BYTES_DEF : sequential PC increment in bytes
package fetch_pkg;

    localparam int unsigned XLEN_DEF        = 64;
    localparam int unsigned ILEN_DEF        = 32;
    localparam int unsigned INSTR_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Purpose     : reads the PC, issues one imem read at a time, hands instr+PC to decode, drives PC reg write.
// Latency     : request accept -> response -> fetch_valid one cycle later; at best one instruction per 3 cycles.
// Backpressure: imem_req_ready holds REQ; fetch_ready=0 holds HOLD with instr/PC stable and no new request.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   pc_in                             current PC (PC register output)
//   pc_enable / pc_next               PC register write enable / write data
//   redirect_valid / redirect_pc      single-cycle branch/jump redirect
//   imem_req_valid/ready/addr         instruction memory read request
//   imem_resp_valid/data              in-order read response, one per accepted request
//   fetch_valid/ready/instr/pc        instruction handed to decode
//   fetch_misalign                    (MISALIGN_TRAP_EN only) held entry is a misaligned-PC trap
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned PCs instead of issuing a
// word-aligned read.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned ILEN        = ILEN_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_enable,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [ILEN-1:0] fetch_instr,
`ifdef MISALIGN_TRAP_EN
    output logic            fetch_misalign,
`endif
    output logic [XLEN-1:0] fetch_pc
);

    fetch_state_e    state_q, state_d;
    logic            stale_q, stale_d;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] fpc_q;

    logic            redir;
    logic            pc_misaligned;
    logic [XLEN-1:0] req_addr;
    logic            req_fire;
    logic            resp_take;
    logic            mis_hit;
    logic [XLEN-1:0] pc_seq;

    // Redirect is masked while in reset so every output reads 0 during reset.
    assign redir = redirect_valid & reset_n;

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    assign pc_misaligned  = |pc_in[1:0];
    assign req_addr       = pc_in;
    assign fetch_misalign = mis_q;
`else
    assign pc_misaligned  = 1'b0;
    assign req_addr       = {pc_in[XLEN-1:2], 2'b00};
`endif

    assign req_fire  = (state_q == REQ) & ~redir & ~pc_misaligned & imem_req_ready;
    assign mis_hit   = (state_q == REQ) & ~redir & pc_misaligned;
    // A response consumed by a redirect in the same cycle is dropped.
    assign resp_take = (state_q == WAIT) & imem_resp_valid & ~stale_q & ~redir;
    // Wraps modulo 2^XLEN; carry-out is discarded.
    assign pc_seq    = pc_q + XLEN'(INSTR_BYTES);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        stale_d = stale_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redir)         state_d = REQ;
                else if (mis_hit)  state_d = HOLD;
                else if (req_fire) state_d = WAIT;
            end
            WAIT: begin
                if (redir) begin
                    // If the outstanding response lands now, nothing remains in
                    // flight; otherwise mark it to be discarded on arrival.
                    if (imem_resp_valid) begin
                        state_d = REQ;
                        stale_d = 1'b0;
                    end else begin
                        stale_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    state_d = stale_q ? REQ : HOLD;
                    stale_d = 1'b0;
                end
            end
            HOLD: begin
                if (redir || fetch_ready) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        fetch_valid    = 1'b0;
        pc_enable      = 1'b0;
        pc_next        = '0;
        if (redir) begin
            pc_enable = 1'b1;
            pc_next   = redirect_pc;
        end
        case (state_q)
            REQ: begin
                imem_req_addr  = req_addr;
                imem_req_valid = ~redir & ~pc_misaligned;
            end
            WAIT: begin
                if (resp_take) begin
                    pc_enable = 1'b1;
                    pc_next   = pc_seq;
                end
            end
            HOLD:    fetch_valid = ~redir;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            fpc_q   <= '0;
        end else begin
            if (req_fire) pc_q <= pc_in;
            if (resp_take) begin
                instr_q <= imem_resp_data;
                fpc_q   <= pc_q;
            end else if (mis_hit) begin
                instr_q <= '0;
                fpc_q   <= pc_in;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mis_q <= 1'b0;
        end else if (mis_hit) begin
            mis_q <= 1'b1;
        end else if ((state_q == HOLD) && (redir || fetch_ready)) begin
            mis_q <= 1'b0;
        end
    end
`endif

    assign fetch_instr = instr_q;
    assign fetch_pc    = fpc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model
// of the fetch unit plus a PC register and instruction memory owned here.
// Build option MISALIGN_TRAP_EN is mirrored here.
module tb_instr_fetch_ctrl;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [XLEN-1:0] pc_in;
    logic            pc_enable;
    logic [XLEN-1:0] pc_next;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [ILEN-1:0] fetch_instr;
    logic [XLEN-1:0] fetch_pc;
`ifdef MISALIGN_TRAP_EN
    logic            fetch_misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc_in           (pc_in),
        .pc_enable       (pc_enable),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_instr     (fetch_instr),
`ifdef MISALIGN_TRAP_EN
        .fetch_misalign  (fetch_misalign),
`endif
        .fetch_pc        (fetch_pc)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Stimulus knobs
    logic            d_rst_n, d_rdy, d_redir, d_fready;
    logic [XLEN-1:0] d_redir_pc;

    // Instruction memory: at most one response pending
    logic            mem_pend;
    int              mem_cnt;
    logic [ILEN-1:0] mem_dat;
    int              nxt_lat;
    logic [ILEN-1:0] nxt_dat;
    logic            resp;

    // Fetch unit model (transaction level)
    logic            m_run;      // has left reset-idle
    logic            m_wait;     // a read is outstanding
    logic            m_stale;    // outstanding read was overtaken by a redirect
    logic            m_hold;     // an entry is being offered to decode
    logic            m_mis;
    logic [ILEN-1:0] m_instr;
    logic [XLEN-1:0] m_fpc;
    logic [XLEN-1:0] m_reqpc;
    logic [XLEN-1:0] pc_reg;     // the PC register itself

    logic            e_req_valid, e_pen, e_fvalid, e_mis;
    logic [XLEN-1:0] e_addr, e_pnext;
    logic            in_req, misal;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, predict and compare outputs.
    task automatic cyc_begin();
        @(negedge clk);
        reset_n        = d_rst_n;
        redirect_valid = d_redir;
        redirect_pc    = d_redir_pc;
        imem_req_ready = d_rdy;
        fetch_ready    = d_fready;
        pc_in          = pc_reg;
        resp           = mem_pend && (mem_cnt == 0);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_dat : 32'h0BAD_F00D;
        if (!d_rst_n) begin
            m_run = 0; m_wait = 0; m_stale = 0; m_hold = 0; m_mis = 0;
            m_instr = '0; m_fpc = '0;
        end
`ifdef MISALIGN_TRAP_EN
        misal = (pc_reg[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        in_req      = m_run && !m_wait && !m_hold;
        e_req_valid = 0; e_addr = '0; e_pen = 0; e_pnext = '0; e_fvalid = 0;
        if (d_rst_n && d_redir) begin
            e_pen = 1; e_pnext = d_redir_pc;
        end
        if (in_req) begin
`ifdef MISALIGN_TRAP_EN
            e_addr = pc_reg;
`else
            e_addr = pc_reg & ~64'h3;
`endif
            e_req_valid = !d_redir && !misal;
        end
        if (m_hold) e_fvalid = !d_redir;
        if (m_wait && resp && !m_stale && !d_redir) begin
            e_pen = 1; e_pnext = m_reqpc + 64'd4;
        end
        e_mis = m_mis;
        #1;
        chk("req_valid", imem_req_valid, e_req_valid);
        chk("req_addr",  imem_req_addr,  e_addr);
        chk("pc_enable", pc_enable,      e_pen);
        chk("pc_next",   pc_next,        e_pnext);
        chk("fetch_valid", fetch_valid,  e_fvalid);
        chk("fetch_instr", fetch_instr,  m_instr);
        chk("fetch_pc",    fetch_pc,     m_fpc);
`ifdef MISALIGN_TRAP_EN
        chk("fetch_misalign", fetch_misalign, e_mis);
`endif
    endtask

    // Advance model, PC register and memory across the clock edge.
    task automatic cyc_end();
        logic acc;
        @(posedge clk);
        acc = e_req_valid && d_rdy;
        if (d_rst_n) begin
            if (!m_run) begin
                m_run = 1;
            end else if (d_redir) begin
                if (m_wait) begin
                    if (resp) begin m_wait = 0; m_stale = 0; end
                    else m_stale = 1;
                end
                m_hold = 0; m_mis = 0;
            end else if (in_req) begin
                if (misal) begin
                    m_hold = 1; m_mis = 1; m_instr = '0; m_fpc = pc_reg;
                end else if (d_rdy) begin
                    m_wait = 1; m_reqpc = pc_reg;
                end
            end else if (m_wait) begin
                if (resp) begin
                    m_wait = 0;
                    if (m_stale) m_stale = 0;
                    else begin m_hold = 1; m_instr = mem_dat; m_fpc = m_reqpc; end
                end
            end else if (m_hold && d_fready) begin
                m_hold = 0; m_mis = 0;
            end
            if (e_pen) pc_reg = e_pnext;
        end
        if (resp) mem_pend = 0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_pend = 1; mem_cnt = nxt_lat; mem_dat = nxt_dat;
        end
    endtask

    task automatic cyc();
        cyc_begin();
        cyc_end();
    endtask

    initial begin
        d_rst_n = 0; d_rdy = 0; d_redir = 0; d_fready = 0; d_redir_pc = '0;
        mem_pend = 0; mem_cnt = 0; mem_dat = '0; nxt_lat = 0; nxt_dat = '0;
        m_run = 0; m_wait = 0; m_stale = 0; m_hold = 0; m_mis = 0;
        m_instr = '0; m_fpc = '0; m_reqpc = '0; pc_reg = '0;
        reset_n = 0; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
        fetch_ready = 0; pc_in = '0; imem_resp_valid = 0; imem_resp_data = '0;

        // Power-on reset
        cyc_begin();
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_pc_enable", pc_enable, 1'b0);
        cyc_end();
        cyc();

        // Sequential fetch from 0x1000
        d_rst_n = 1; pc_reg = 64'h1000; d_rdy = 1; nxt_lat = 0; nxt_dat = 32'h0050_0093;
        cyc_begin(); chk("idle_req_valid", imem_req_valid, 1'b0); cyc_end();
        cyc_begin(); chk("seq_req_valid", imem_req_valid, 1'b1);
                     chk("seq_req_addr", imem_req_addr, 64'h1000); cyc_end();
        cyc_begin(); chk("seq_pc_enable", pc_enable, 1'b1);
                     chk("seq_pc_next", pc_next, 64'h1004); cyc_end();
        // Decode backpressure
        for (int i = 0; i < 6; i++) begin
            cyc_begin();
            chk("bp_fetch_valid", fetch_valid, 1'b1);
            chk("bp_fetch_instr", fetch_instr, 64'h0050_0093);
            chk("bp_fetch_pc", fetch_pc, 64'h1000);
            chk("bp_no_req", imem_req_valid, 1'b0);
            cyc_end();
        end
        d_fready = 1; cyc(); d_fready = 0;
        nxt_lat = 2; nxt_dat = 32'h1111_2222;
        cyc_begin(); chk("seq2_req_addr", imem_req_addr, 64'h1004); cyc_end();

        // Redirect while waiting: late response dropped
        d_redir = 1; d_redir_pc = 64'h2000;
        cyc_begin(); chk("rd_pc_enable", pc_enable, 1'b1);
                     chk("rd_pc_next", pc_next, 64'h2000); cyc_end();
        d_redir = 0;
        cyc();
        cyc_begin(); chk("rd_resp_dropped_pen", pc_enable, 1'b0); cyc_end();
        // Redirect in REQ (memory stalled) to the last word of the address space
        d_rdy = 0; d_redir = 1; d_redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc_begin(); chk("rd_next_addr", imem_req_addr, 64'h2000);
                     chk("rd_no_fvalid", fetch_valid, 1'b0);
                     chk("rd_req_forced0", imem_req_valid, 1'b0); cyc_end();
        d_redir = 0; d_rdy = 1; nxt_lat = 0; nxt_dat = 32'hCAFE_0013;
        cyc_begin(); chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC); cyc_end();
        cyc_begin(); chk("wrap_pc_next", pc_next, 64'h0); cyc_end();
        d_fready = 1;
        cyc_begin(); chk("wrap_fetch_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC); cyc_end();
        d_fready = 0; nxt_lat = 5;
        cyc_begin(); chk("wrap_next_addr", imem_req_addr, 64'h0); cyc_end();

        // Reset in the middle of a wait, stale response arrives in idle
        cyc();
        d_rst_n = 0;
        cyc_begin();
        chk("mid_rst_req_valid", imem_req_valid, 1'b0);
        chk("mid_rst_req_addr", imem_req_addr, 64'h0);
        chk("mid_rst_fetch_pc", fetch_pc, 64'h0);
        chk("mid_rst_fetch_instr", fetch_instr, 64'h0);
        cyc_end();
        d_rst_n = 1; mem_cnt = 0; nxt_lat = 0; nxt_dat = 32'h0000_0013;
        cyc_begin(); chk("post_rst_idle", imem_req_valid, 1'b0);
                     chk("post_rst_resp_ignored", pc_enable, 1'b0); cyc_end();
        cyc_begin(); chk("post_rst_req_valid", imem_req_valid, 1'b1);
                     chk("post_rst_req_addr", imem_req_addr, 64'h0); cyc_end();
        cyc();
        // Misaligned redirect target, issued from HOLD
        d_redir = 1; d_redir_pc = 64'h1002;
        cyc();
        d_redir = 0;
`ifdef MISALIGN_TRAP_EN
        cyc_begin(); chk("mis_no_req", imem_req_valid, 1'b0);
                     chk("mis_no_pen", pc_enable, 1'b0); cyc_end();
        d_fready = 1;
        cyc_begin(); chk("mis_flag", fetch_misalign, 1'b1);
                     chk("mis_fetch_pc", fetch_pc, 64'h1002);
                     chk("mis_fetch_instr", fetch_instr, 64'h0); cyc_end();
        d_fready = 0;
`else
        cyc_begin(); chk("mis_req_addr_aligned", imem_req_addr, 64'h1000); cyc_end();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d_rdy    = ($urandom % 4) != 0;
            d_fready = ($urandom % 3) != 0;
            d_redir  = ($urandom % 10) == 0;
            d_redir_pc = {$urandom, $urandom};
            if (($urandom % 8) != 0) d_redir_pc[1:0] = 2'b00;
            if (($urandom % 16) == 0) d_redir_pc = 64'hFFFF_FFFF_FFFF_FFF8;
            nxt_lat = $urandom % 4;
            nxt_dat = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
